// File: rtl/trig_echo_ctrl.sv
// Ultrasonic ranging controller: issues a trigger pulse, times the echo high
// width in clocks, and enforces a holdoff gap between measurements.
module trig_echo_ctrl #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int HOLDOFF_CYCLES = 3000000,
    parameter int CNT_W          = 22
) (
    input  logic             CLKOUT1,
    input  logic             reset,
    input  logic             pulse,
    input  logic             mode,
    input  logic             ECHO,
    output logic             trigg,
    output logic             busy,
    output logic             dist_valid,
    output logic [CNT_W-1:0] dist_count,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] echo_hi;
    logic             echo_s1, echo_s;
    logic             pulse_d;

    // The WAIT_RISE cycle that saw the echo is itself a high cycle, so in
    // MEASURE the echo high time so far is one more than the counter.
    assign echo_hi = cnt + 1'b1;

    always_ff @(posedge CLKOUT1) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            echo_s1    <= 1'b0;
            echo_s     <= 1'b0;
            pulse_d    <= 1'b0;
            trigg      <= 1'b0;
            busy       <= 1'b0;
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
            dist_count <= '0;
        end else begin
            echo_s1    <= ECHO;
            echo_s     <= echo_s1;
            pulse_d    <= pulse;
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if ((pulse && !pulse_d) || mode) begin
                        state <= TRIG;
                        cnt   <= '0;
                        trigg <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state <= WAIT_RISE;
                        cnt   <= '0;
                        trigg <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (echo_s) begin
                        state <= MEASURE;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state   <= HOLDOFF;
                        cnt     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        state      <= HOLDOFF;
                        cnt        <= '0;
                        dist_count <= echo_hi;
                        dist_valid <= 1'b1;
                    end else if (echo_hi == TO_LAST) begin
                        // this high cycle brings the width to the limit
                        state   <= HOLDOFF;
                        cnt     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    trigg <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_echo_ctrl.sv
// Self-checking bench for trig_echo_ctrl: directed scenarios plus randomized
// echo delays/widths checked against expectations derived from the timing rules.
module tb_trig_echo_ctrl;

    localparam int TRIG  = 4;
    localparam int TO    = 50;
    localparam int HOLD  = 10;
    localparam int CNT_W = 22;

    logic             CLKOUT1 = 1'b0;
    logic             reset   = 1'b0;
    logic             pulse   = 1'b0;
    logic             mode    = 1'b0;
    logic             ECHO    = 1'b0;
    logic             trigg, busy, dist_valid, timeout;
    logic [CNT_W-1:0] dist_count;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] model_dist = '0;

    trig_echo_ctrl #(
        .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HOLD), .CNT_W(CNT_W)
    ) dut (
        .CLKOUT1(CLKOUT1), .reset(reset), .pulse(pulse), .mode(mode), .ECHO(ECHO),
        .trigg(trigg), .busy(busy), .dist_valid(dist_valid),
        .dist_count(dist_count), .timeout(timeout)
    );

    always #10 CLKOUT1 = ~CLKOUT1;

    // passive event recorder, sampled on the falling edge
    int cyc = 0;
    int dv_n = 0, to_n = 0, both_n = 0, trig_rises = 0;
    int st_cyc = 0, to_cyc = 0, tfall_cyc = 0, bfall_cyc = 0;
    logic [CNT_W-1:0] dv_val = '0;
    logic trigg_q = 1'b0, busy_q = 1'b0;

    always @(posedge CLKOUT1) cyc <= cyc + 1;

    always @(negedge CLKOUT1) begin
        if (trigg && !trigg_q) trig_rises <= trig_rises + 1;
        if (!trigg && trigg_q) tfall_cyc <= cyc;
        if (!busy && busy_q)   bfall_cyc <= cyc;
        if (dist_valid) begin
            dv_n   <= dv_n + 1;
            dv_val <= dist_count;
            st_cyc <= cyc;
        end
        if (timeout) begin
            to_n   <= to_n + 1;
            to_cyc <= cyc;
            st_cyc <= cyc;
        end
        if (dist_valid && timeout) both_n <= both_n + 1;
        trigg_q <= trigg;
        busy_q  <= busy;
    end

    task automatic tick();
        @(posedge CLKOUT1);
        #1;
    endtask

    // One measurement: w = echo width in clocks (0 = no echo), d = delay after
    // the trigger falls. Width >= TO, or no echo, must end in a timeout.
    task automatic run_meas(input bit use_pulse, input bit toggle, input bit clr_mode,
                            input int d, input int w);
        int n, dv0, to0, bo0, tr0, exp_n;
        bit exp_to;
        logic [CNT_W-1:0] exp_dist;
        exp_to   = (w == 0) || (w >= TO);
        exp_dist = exp_to ? model_dist : CNT_W'(w);
        dv0 = dv_n; to0 = to_n; bo0 = both_n; tr0 = trig_rises;
        if (use_pulse) begin pulse = 1'b1; tick(); pulse = 1'b0; end
        n = 0;
        while (!trigg && n < 20) begin tick(); n++; end
        exp_n = use_pulse ? 0 : 1;
        checks++;
        if (n != exp_n) begin
            errors++; $display("FAIL trig_start got %0d cycles want %0d", n, exp_n);
        end
        if (clr_mode) mode = 1'b0;
        n = 0;
        while (trigg && n < 20) begin
            n++;
            if (toggle) pulse = ~pulse;
            tick();
        end
        checks++;
        if (n != TRIG) begin errors++; $display("FAIL trig_len got %0d want %0d", n, TRIG); end
        repeat (d) begin if (toggle && busy) pulse = ~pulse; tick(); end
        if (w > 0) begin
            ECHO = 1'b1;
            repeat (w) begin if (toggle && busy) pulse = ~pulse; tick(); end
            ECHO = 1'b0;
        end
        n = 0;
        while (busy && n < 300) begin if (toggle) pulse = ~pulse; tick(); n++; end
        pulse = 1'b0;
        if (use_pulse) repeat (3) tick();
        else begin @(negedge CLKOUT1); #1; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_end got %b want 0", busy); end
        checks++;
        if (dv_n - dv0 != (exp_to ? 0 : 1)) begin
            errors++; $display("FAIL dv_count got %0d want %0d", dv_n - dv0, exp_to ? 0 : 1);
        end
        checks++;
        if (to_n - to0 != (exp_to ? 1 : 0)) begin
            errors++; $display("FAIL to_count got %0d want %0d", to_n - to0, exp_to ? 1 : 0);
        end
        checks++;
        if (both_n != bo0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", both_n - bo0); end
        checks++;
        if (dist_count !== exp_dist) begin
            errors++; $display("FAIL dist_count got %0d want %0d (w=%0d)", dist_count, exp_dist, w);
        end
        if (!exp_to) begin
            checks++;
            if (dv_val !== CNT_W'(w)) begin
                errors++; $display("FAIL dv_value got %0d want %0d", dv_val, w);
            end
        end
        checks++;
        if (bfall_cyc - st_cyc != HOLD) begin
            errors++; $display("FAIL holdoff got %0d want %0d", bfall_cyc - st_cyc, HOLD);
        end
        if (w == 0) begin
            checks++;
            if (to_cyc - tfall_cyc != TO) begin
                errors++; $display("FAIL wait_timeout got %0d want %0d", to_cyc - tfall_cyc, TO);
            end
        end
        checks++;
        if (trig_rises - tr0 != 1) begin
            errors++; $display("FAIL trig_count got %0d want 1", trig_rises - tr0);
        end
        if (!exp_to) model_dist = CNT_W'(w);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (trigg !== 1'b0) begin errors++; $display("FAIL rst_trigg got %b want 0", trigg); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++;
        if (dist_valid !== 1'b0) begin errors++; $display("FAIL rst_dv got %b want 0", dist_valid); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL rst_to got %b want 0", timeout); end
        checks++;
        if (dist_count !== '0) begin errors++; $display("FAIL rst_dist got %0d want 0", dist_count); end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        run_meas(1'b1, 1'b0, 1'b0, 3, 20);
    endtask

    task automatic test_no_echo();
        run_meas(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_stuck_high();
        run_meas(1'b1, 1'b0, 1'b0, 2, 90);
    endtask

    task automatic test_boundary();
        run_meas(1'b1, 1'b0, 1'b0, 0, TO - 1);
        run_meas(1'b1, 1'b0, 1'b0, 5, TO);
        run_meas(1'b1, 1'b0, 1'b0, 1, 1);
    endtask

    // echo raised during the trigger: raw echo drops k ticks after WAIT_RISE
    // entry, and its synchronized copy stays high 2 cycles longer
    task automatic test_echo_early();
        int k, n, dv0;
        k = 6;
        dv0 = dv_n;
        pulse = 1'b1; tick(); pulse = 1'b0; tick();
        ECHO = 1'b1;
        n = 0;
        while (trigg && n < 20) begin tick(); n++; end
        repeat (k) tick();
        ECHO = 1'b0;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        repeat (2) tick();
        checks++;
        if (dv_n - dv0 != 1 || dv_val !== CNT_W'(k + 2)) begin
            errors++; $display("FAIL echo_early got %0d (n=%0d) want %0d", dv_val, dv_n - dv0, k + 2);
        end
        model_dist = CNT_W'(k + 2);
    endtask

    task automatic test_ignore();
        run_meas(1'b1, 1'b1, 1'b0, 4, 15);
    endtask

    task automatic test_back_to_back();
        int tr0;
        mode = 1'b1;
        run_meas(1'b0, 1'b0, 1'b0, $urandom_range(0, 10), 7);
        run_meas(1'b0, 1'b0, 1'b0, $urandom_range(0, 10), 7);
        run_meas(1'b0, 1'b0, 1'b1, $urandom_range(0, 10), 7);
        tr0 = trig_rises;
        repeat (20) tick();
        checks++;
        if (trig_rises != tr0) begin errors++; $display("FAIL mode_stop got %0d rises want 0", trig_rises - tr0); end
    endtask

    task automatic test_random();
        int d, w;
        for (int i = 0; i < 8; i++) begin
            d = $urandom_range(0, 20);
            w = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 70);
            run_meas(1'b1, 1'($urandom_range(0, 1)), 1'b0, d, w);
        end
    endtask

    task automatic test_reset_mid();
        int dv0, to0, n;
        dv0 = dv_n; to0 = to_n;
        pulse = 1'b1; tick(); pulse = 1'b0; tick();
        reset = 1'b0; tick();
        checks++;
        if ({trigg, busy, dist_valid, timeout} !== 4'b0) begin
            errors++; $display("FAIL rst_trig got %b want 0000", {trigg, busy, dist_valid, timeout});
        end
        reset = 1'b1; repeat (5) tick();
        checks++;
        if (trigg !== 1'b0) begin errors++; $display("FAIL rst_trig_restart got %b want 0", trigg); end
        pulse = 1'b1; tick(); pulse = 1'b0;
        repeat (TRIG) tick();
        ECHO = 1'b1;
        repeat (12) tick();
        reset = 1'b0; tick();
        checks++;
        if ({trigg, busy, dist_valid, timeout} !== 4'b0 || dist_count !== '0) begin
            errors++; $display("FAIL rst_meas got %b dist %0d want 0000 dist 0",
                               {trigg, busy, dist_valid, timeout}, dist_count);
        end
        model_dist = '0;
        reset = 1'b1; repeat (5) tick();
        ECHO = 1'b0; repeat (70) tick();
        checks++;
        if (dv_n != dv0 || to_n != to0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_strobe got dv %0d to %0d busy %b want 0 0 0",
                               dv_n - dv0, to_n - to0, busy);
        end
        pulse = 1'b1; reset = 1'b0; repeat (2) tick();
        reset = 1'b1; tick();
        checks++;
        if (trigg !== 1'b1) begin errors++; $display("FAIL rst_pulse_held got %b want 1", trigg); end
        pulse = 1'b0;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        repeat (2) tick();
        checks++;
        if (to_n - to0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_pulse_meas got to %0d busy %b want 1 0", to_n - to0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_echo();
        test_stuck_high();
        test_boundary();
        test_echo_early();
        test_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trig_echo_ctrl.md
TRIG_ECHO_CTRL -- requirements
Module: trig_echo_ctrl

Interface
REQ-001 The block SHALL have parameter TRIG_CYCLES, default 500, giving the trigger high time in clocks (10 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1900000, giving the maximum echo wait time and the maximum echo width in clocks.
REQ-003 The block SHALL have parameter HOLDOFF_CYCLES, default 3000000, giving the idle gap after each measurement in clocks.
REQ-004 The block SHALL have parameter CNT_W, default 22, giving the width of all internal counters and of dist_count; it shall satisfy 2^CNT_W > max(TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES).
REQ-005 Port CLKOUT1  input  1  is the single clock; all logic is on its rising edge.
REQ-006 Port reset  input  1  is the synchronous, active-low reset.
REQ-007 Port pulse  input  1  is the measurement request; only a rising edge counts.
REQ-008 Port mode  input  1  selects single-shot operation (0) or continuous re-triggering (1).
REQ-009 Port ECHO  input  1  is the asynchronous sensor echo.
REQ-010 Port trigg  output  1  is the registered sensor trigger.
REQ-011 Port busy  output  1  is high whenever the FSM is not in IDLE.
REQ-012 Port dist_valid  output  1  is a one-cycle strobe marking a new dist_count.
REQ-013 Port dist_count  output  CNT_W  is the last echo high time in clocks.
REQ-014 Port timeout  output  1  is a one-cycle strobe marking a failed measurement.

Function
REQ-015 ECHO SHALL pass through a 2-flop synchronizer before any use, giving 2 cycles of latency; measured widths are unaffected by this latency.
REQ-016 pulse SHALL be registered each cycle as pulse_d; a start request is pulse=1 & pulse_d=0.
REQ-017 The FSM SHALL have states IDLE, TRIG, WAIT_RISE, MEASURE and HOLDOFF, with a single shared counter cleared on every state entry.
REQ-018 IDLE -> TRIG SHALL occur on the edge where a start request is sampled, or on any edge while mode=1.
REQ-019 In TRIG, trigg SHALL be high for exactly TRIG_CYCLES consecutive cycles, starting the cycle after the IDLE->TRIG edge; the FSM then enters WAIT_RISE.
REQ-020 WAIT_RISE -> MEASURE SHALL occur when the synchronized echo is 1.
REQ-021 If the counter reaches TIMEOUT_CYCLES in WAIT_RISE, the block SHALL pulse timeout for 1 cycle and enter HOLDOFF.
REQ-022 In MEASURE, the counter SHALL increment every cycle the synchronized echo is 1.
REQ-023 On the synchronized echo falling edge in MEASURE, the block SHALL load dist_count with the count (the echo high cycles), pulse dist_valid for 1 cycle in the following cycle, and enter HOLDOFF.
REQ-024 If the count reaches TIMEOUT_CYCLES in MEASURE, the block SHALL pulse timeout, leave dist_count unchanged, and enter HOLDOFF; the counter shall never wrap.
REQ-025 HOLDOFF SHALL last HOLDOFF_CYCLES cycles, then go to IDLE.
REQ-026 Start requests outside IDLE SHALL be ignored and not queued, and pulse_d shall keep tracking so that no stale edge fires later.
REQ-027 dist_valid and timeout SHALL never assert in the same cycle, and each shall assert at most once per measurement.
REQ-028 A mode change takes effect only in IDLE; a measurement in progress always completes.
REQ-029 An echo already high on entry to WAIT_RISE SHALL be measured from that cycle.

Reset
REQ-030 With reset=0 at a clock edge, the block SHALL set state=IDLE, trigg=0, busy=0, dist_valid=0, timeout=0, dist_count=0, counter=0, pulse_d=0 and synchronizer flops=0.
REQ-031 Reset SHALL take priority over all other inputs, including mid-trigger (trigg drops the next cycle) and mid-measurement (no strobe is issued).
REQ-032 After reset release, a pulse already high SHALL count as a rising edge.

Verification (TRIG_CYCLES=4, TIMEOUT_CYCLES=50, HOLDOFF_CYCLES=10)
REQ-033 Scenario: pulse rises, ECHO goes high 3 cycles after trigg falls and stays high 20 cycles -> trigg high for exactly 4 cycles; dist_count=20; dist_valid=1 for 1 cycle; busy returns low 10 cycles later.
REQ-034 Scenario: ECHO stays low -> timeout strobe 50 cycles after WAIT_RISE entry; dist_count keeps its prior value; the FSM returns to IDLE.
REQ-035 Scenario: ECHO stuck high -> timeout when the count reaches 50; dist_valid stays 0.
REQ-036 Scenario: pulse is toggled during TRIG, MEASURE and HOLDOFF -> exactly one measurement occurs; no second trigg.
REQ-037 Scenario: mode=1 with ECHO width 7 -> a back-to-back trigger/measure/holdoff cycle repeats; each cycle reports dist_count=7.
REQ-038 Scenario: reset=0 during the 2nd trigg cycle and again during MEASURE -> all outputs are 0 the next cycle; no dist_valid or timeout strobe.
